spi_cmd_controller: RTL

//  Sequences the byte stream delivered by the SPI slave receiver into VGA-side actions:

---
 rtl/spi_vga_pkg.sv | 28 ++
 rtl/fb_fill_engine.sv | 50 +++++
 rtl/spi_cmd_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_vga_pkg.sv
// Shared opcodes, parser state encoding and control-register indices for the
// SPI-to-VGA command path.
package spi_vga_pkg;

    localparam logic [7:0] OP_NOP          = 8'h00;
    localparam logic [7:0] OP_WRITE_PIXELS = 8'h01;
    localparam logic [7:0] OP_WRITE_REG    = 8'h02;
    localparam logic [7:0] OP_CLEAR        = 8'h03;
    localparam logic [7:0] OP_CLR_ERR      = 8'h04;

    localparam logic [1:0] REG_BG_COLOR = 2'd0;
    localparam logic [1:0] REG_FG_COLOR = 2'd1;
    localparam logic [1:0] REG_MODE     = 2'd2;
    localparam logic [1:0] REG_SCROLL   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_REG_IDX,
        ST_REG_VAL,
        ST_CLR_VAL,
        ST_FILL,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/fb_fill_engine.sv
// Walks addresses 0..FB_DEPTH-1 writing one fill value through the framebuffer
// write handshake; done_o marks the cycle of the final transfer.
module fb_fill_engine #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned FB_DEPTH = 19200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        value_i,
    input  logic              fb_ready_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wdata_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    logic              act_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        val_q;
    logic              last_xfer;

    assign last_xfer = act_q & fb_ready_i & (addr_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= 1'b0;
            addr_q <= '0;
            val_q  <= '0;
        end else if (start_i) begin
            act_q  <= 1'b1;
            addr_q <= '0;
            val_q  <= value_i;
        end else if (act_q && fb_ready_i) begin
            if (last_xfer) begin
                act_q <= 1'b0;
            end else begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign we_o    = act_q;
    assign addr_o  = addr_q;
    assign wdata_o = val_q;
    assign done_o  = last_xfer;

endmodule

// File: rtl/spi_cmd_controller.sv
// Parses SPI command frames into framebuffer pixel writes, control-register
// writes and hardware fills; fb_* is shared between the pending slot and the fill engine.
module spi_cmd_controller
    import spi_vga_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned FB_DEPTH = 19200,
    parameter int unsigned REG_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              reg_we,
    output logic [REG_W-1:0]  reg_idx,
    output logic [7:0]        reg_wdata,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    state_t            state_q;
    logic              pend_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        addr_hi_q;
    logic [7:0]        fill_val_q;
    logic [REG_W-1:0]  reg_idx_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_we_q;
    logic              busy_q;
    logic              err_q;

    logic              fill_start;
    logic              fill_we;
    logic              fill_done;
    logic [ADDR_W-1:0] fill_addr;
    logic [7:0]        fill_wdata;

    logic              pend_xfer;
    logic              slot_blocked;
    logic [15:0]       raw_addr;
    logic              addr_ok;
    logic              in_parse;

    assign pend_xfer    = pend_q & fb_ready;
    assign slot_blocked = pend_q & ~fb_ready;
    assign raw_addr     = {addr_hi_q, rx_data};
    assign addr_ok      = ({16'd0, raw_addr} < FB_DEPTH);
    assign in_parse     = (state_q != ST_IDLE) && (state_q != ST_FILL);
    // Fill waits for any pixel still pending from an earlier frame to drain.
    assign fill_start   = (state_q == ST_FILL) & ~fill_we & ~pend_q;

    fb_fill_engine #(
        .ADDR_W  (ADDR_W),
        .FB_DEPTH(FB_DEPTH)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .start_i   (fill_start),
        .value_i   (fill_val_q),
        .fb_ready_i(fb_ready),
        .we_o      (fill_we),
        .addr_o    (fill_addr),
        .wdata_o   (fill_wdata),
        .done_o    (fill_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            addr_hi_q   <= '0;
            fill_val_q  <= '0;
            reg_idx_q   <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            if (pend_xfer) begin
                pend_q <= 1'b0;
                addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            end

            if (in_parse && !cs_active) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: if (cs_active && rx_valid) begin
                        unique case (rx_data)
                            OP_NOP:          state_q <= ST_DISCARD;
                            OP_WRITE_PIXELS: state_q <= ST_ADDR_HI;
                            OP_WRITE_REG:    state_q <= ST_REG_IDX;
                            OP_CLEAR:        state_q <= ST_CLR_VAL;
                            OP_CLR_ERR: begin
                                err_q   <= 1'b0;
                                state_q <= ST_DISCARD;
                            end
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= ST_DISCARD;
                            end
                        endcase
                    end
                    ST_ADDR_HI: if (rx_valid) begin
                        addr_hi_q <= rx_data;
                        state_q   <= ST_ADDR_LO;
                    end
                    // Reloading the address under a stalled write would move it; treat as overrun.
                    ST_ADDR_LO: if (rx_valid) begin
                        if (!addr_ok || slot_blocked) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DISCARD;
                        end else begin
                            addr_q  <= ADDR_W'(raw_addr);
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: if (rx_valid) begin
                        if (slot_blocked) begin
                            err_q <= 1'b1;
                        end else begin
                            pend_q  <= 1'b1;
                            wdata_q <= rx_data;
                        end
                    end
                    ST_REG_IDX: if (rx_valid) begin
                        reg_idx_q <= rx_data[REG_W-1:0];
                        state_q   <= ST_REG_VAL;
                    end
                    ST_REG_VAL: if (rx_valid) begin
                        reg_wdata_q <= rx_data;
                        reg_we_q    <= 1'b1;
                        state_q     <= ST_DISCARD;
                    end
                    ST_CLR_VAL: if (rx_valid) begin
                        fill_val_q <= rx_data;
                        busy_q     <= 1'b1;
                        state_q    <= ST_FILL;
                    end
                    ST_FILL: begin
                        if (rx_valid) err_q <= 1'b1;
                        if (fill_done) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DISCARD: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign fb_we     = pend_q | fill_we;
    assign fb_addr   = fill_we ? fill_addr : addr_q;
    assign fb_wdata  = fill_we ? fill_wdata : wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_idx   = reg_idx_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
